// File: rtl/ram16k_block_mover_pkg.sv
// ram16k_block_mover_pkg: widths, FSM state encodings and mode constants shared by the block mover.
package ram16k_block_mover_pkg;
   localparam int AW = 14;
   localparam int DW = 16;
   localparam int LW = AW + 1;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_FILL  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/ram16k_block_mover_mem_ptr_counter.sv
// mem_ptr_counter: address pointer with async clear, parallel load and wrapping increment.
module mem_ptr_counter #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_val,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr
);
   logic [AW-1:0] r_ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_ptr <= '0;
      else if (i_load) r_ptr <= i_load_val;
      else if (i_inc) r_ptr <= r_ptr + AW'(1);
   assign o_ptr = r_ptr;
endmodule

// File: rtl/ram16k_block_mover.sv
// ram16k_block_mover: copies a block between memory regions or fills a region with a constant,
// driving the 16K-word data memory port from registered state only.
import ram16k_block_mover_pkg::*;
module ram16k_block_mover (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic          i_mode,
   input  logic [AW-1:0] i_src_addr,
   input  logic [AW-1:0] i_dst_addr,
   input  logic [LW-1:0] i_length,
   input  logic [DW-1:0] i_fill_value,
   output logic          o_busy,
   output logic          o_done,
   output logic [DW-1:0] o_mem_in,
   output logic          o_mem_load,
   output logic [AW-1:0] o_mem_address,
   input  logic [DW-1:0] i_mem_out
);
   localparam logic [LW-1:0] MAX_LEN = LW'(1) << AW;
   logic [2:0]    r_state;
   logic [DW-1:0] r_fill, r_data, r_in_hold;
   logic [LW-1:0] r_rem, w_len;
   logic [AW-1:0] r_addr_hold, w_src_ptr, w_dst_ptr;
   logic          w_accept, w_write, w_last;
   assign w_accept = (r_state == ST_IDLE) && i_start;
   assign w_write  = (r_state == ST_WRITE) || (r_state == ST_FILL);
   assign w_last   = (r_rem == LW'(1));
   assign w_len    = (i_length > MAX_LEN) ? MAX_LEN : i_length;
   mem_ptr_counter #(.AW(AW)) u_src_ptr (
      .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_val(i_src_addr),
      .i_inc(r_state == ST_WRITE), .o_ptr(w_src_ptr));
   mem_ptr_counter #(.AW(AW)) u_dst_ptr (
      .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_load_val(i_dst_addr),
      .i_inc(w_write), .o_ptr(w_dst_ptr));
   // Hold registers keep the bus stable once the FSM leaves the active states.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_fill      <= '0;
         r_data      <= '0;
         r_rem       <= '0;
         r_addr_hold <= '0;
         r_in_hold   <= '0;
      end else begin
         r_addr_hold <= o_mem_address;
         r_in_hold   <= o_mem_in;
         case (r_state)
            ST_IDLE: if (i_start) begin
               r_fill  <= i_fill_value;
               r_rem   <= w_len;
               r_state <= (w_len == '0) ? ST_DONE : (i_mode == MODE_FILL) ? ST_FILL : ST_READ;
            end
            ST_READ: begin
               r_data  <= i_mem_out;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               r_rem   <= r_rem - LW'(1);
               r_state <= w_last ? ST_DONE : ST_READ;
            end
            ST_FILL: begin
               r_rem   <= r_rem - LW'(1);
               r_state <= w_last ? ST_DONE : ST_FILL;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   assign o_mem_address = (r_state == ST_READ) ? w_src_ptr : w_write ? w_dst_ptr : r_addr_hold;
   assign o_mem_in      = (r_state == ST_WRITE) ? r_data : (r_state == ST_FILL) ? r_fill : r_in_hold;
   assign o_mem_load    = w_write;
   assign o_busy        = w_write || (r_state == ST_READ);
   assign o_done        = (r_state == ST_DONE);
endmodule

// File: tb/tb_ram16k_block_mover.sv
// tb_ram16k_block_mover: directed and random copy/fill transfers against a word-array reference memory.
module tb_ram16k_block_mover;
   logic        clk = 1'b0;
   logic        rst_n, start, mode, busy, done, mem_load;
   logic [13:0] src, dst, mem_addr;
   logic [14:0] len;
   logic [15:0] fill, mem_in, mem_out;
   logic [15:0] mem [16384];
   logic [15:0] ref_mem [16384];
   logic        init_en, poke_en;
   logic [13:0] poke_a;
   logic [15:0] poke_d, seed;
   int          errors = 0, checks = 0, done_pulses = 0, load_cycles = 0;

   always #5 clk = ~clk;

   ram16k_block_mover dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_mode(mode), .i_src_addr(src),
      .i_dst_addr(dst), .i_length(len), .i_fill_value(fill), .o_busy(busy), .o_done(done),
      .o_mem_in(mem_in), .o_mem_load(mem_load), .o_mem_address(mem_addr), .i_mem_out(mem_out));

   function automatic logic [15:0] pat(input int i, input logic [15:0] s);
      return 16'(i * 40503) ^ s;
   endfunction

   assign mem_out = mem[mem_addr];
   always @(posedge clk) begin
      if (init_en) for (int i = 0; i < 16384; i++) mem[i] <= pat(i, seed);
      else if (poke_en) mem[poke_a] <= poke_d;
      else if (mem_load) mem[mem_addr] <= mem_in;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mismatches();
      int n = 0;
      for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (done) done_pulses++;
      if (mem_load) load_cycles++;
      chk("bus_rule", {30'd0, mem_load & ~busy, done & busy}, 32'd0);
   endtask

   task automatic poke(input logic [13:0] a, input logic [15:0] d);
      poke_a = a; poke_d = d; poke_en = 1'b1;
      tick();
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run(input logic m, input logic [13:0] s, input logic [13:0] d,
                      input logic [14:0] l, input logic [15:0] f, input bit intrude);
      int L, exp_cyc, cyc, pulses0;
      L = (l > 15'd16384) ? 16384 : int'(l);
      for (int i = 0; i < L; i++) ref_mem[14'(d + i)] = m ? f : ref_mem[14'(s + i)];
      exp_cyc = m ? L : 2 * L;
      load_cycles = 0;
      pulses0 = done_pulses;
      mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < exp_cyc + 20) begin
         if (intrude && cyc == 2) begin
            start = 1'b1; src = ~s; dst = ~d; len = 15'd7; fill = ~f; mode = ~m;
         end else start = 1'b0;
         tick();
         cyc++;
      end
      chk("done_latency", cyc, exp_cyc);
      if (intrude) begin
         start = 1'b1; src = ~s; dst = ~d; len = 15'd5; fill = ~f; mode = ~m;
      end
      tick();
      start = 1'b0;
      chk("done_single", {30'd0, done, busy}, 32'd0);
      tick();
      chk("no_restart", {31'd0, busy}, 32'd0);
      chk("pulse_count", done_pulses - pulses0, 1);
      chk("load_count", load_cycles, L);
      chk("mem_image", mismatches(), 0);
   endtask

   initial begin
      int pulses0;
      logic [13:0] d;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
      init_en = 1'b0; poke_en = 1'b0; poke_a = '0; poke_d = '0; seed = 16'h5A5A;
      #12;
      chk("rst_ctrl", {29'd0, busy, done, mem_load}, 32'd0);
      chk("rst_addr", {18'd0, mem_addr}, 32'd0);
      chk("rst_data", {16'd0, mem_in}, 32'd0);
      for (int i = 0; i < 16384; i++) ref_mem[i] = pat(i, seed);
      init_en = 1'b1;
      tick();
      init_en = 1'b0;
      rst_n = 1'b1;
      tick();
      // Directed copy with known source words
      for (int i = 0; i < 4; i++) poke(14'h0100 + 14'(i), 16'hA000 + 16'(i));
      run(1'b0, 14'h0100, 14'h0200, 15'd4, 16'h0, 1'b0);
      chk("copy_dst_last", {16'd0, mem[14'h0203]}, 32'hA003);
      chk("copy_src_kept", {16'd0, mem[14'h0103]}, 32'hA003);
      // Fill across the top of the address space
      run(1'b1, 14'h0000, 14'h3FFE, 15'd4, 16'hBEEF, 1'b0);
      chk("fill_wrap", {16'd0, mem[14'h0001]}, 32'hBEEF);
      chk("fill_untouched", {16'd0, mem[14'h0002]}, {16'd0, pat(2, seed)});
      run(1'b0, 14'h0123, 14'h0456, 15'd0, 16'h0, 1'b0);
      run(1'b1, 14'h0123, 14'h0456, 15'd0, 16'h1234, 1'b0);
      // Overlapping ascending copy replicates the first word
      poke(14'h0010, 16'h1111);
      run(1'b0, 14'h0010, 14'h0011, 15'd3, 16'h0, 1'b0);
      chk("overlap_last", {16'd0, mem[14'h0013]}, 32'h1111);
      run(1'b0, 14'h2000, 14'h2100, 15'd6, 16'h0, 1'b1);
      run(1'b1, 14'h0, 14'(($urandom)), 15'h7FFF, 16'h0F0F, 1'b0);
      for (int k = 0; k < 10; k++)
         run(1'($urandom), 14'($urandom), 14'($urandom), 15'($urandom_range(0, 40)),
             16'($urandom), 1'($urandom));
      // Abort a long fill with reset while it is writing
      d = 14'($urandom);
      pulses0 = done_pulses;
      mode = 1'b1; dst = d; len = 15'd100; fill = 16'hC0DE; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      for (int i = 0; i < 10; i++) ref_mem[14'(d + i)] = 16'hC0DE;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_async_load", {31'd0, mem_load}, 32'd0);
      chk("rst_async_busy", {31'd0, busy}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("rst_no_done", done_pulses - pulses0, 0);
      chk("rst_mem_image", mismatches(), 0);
      run(1'b0, 14'($urandom), 14'($urandom), 15'd12, 16'h0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
